// File: rtl/riscv_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_pipe
// Description : Two-stage RV32I/RV64I integer ALU pipeline.
//               Stage 1 decodes the instruction and reads the register file.
//               The result of the instruction held in D/E is forwarded into
//               the decode stage. Stage 2 executes the ALU operation into
//               the E/W register and writes the register file.
// Ports       : clk                       - clock, rising edge
//               reset                     - asynchronous reset, active low
//               in_valid/in_ready/in_instr - instruction input handshake
//               out_valid/out_ready       - result output handshake
//               out_result/out_rd/out_illegal - completed instruction
//               dbg_addr/dbg_data         - combinational register-file read
//               retire_cnt/illegal_cnt    - hand-off counters
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     retire_cnt,
    output logic [31:0]     illegal_cnt
);

    localparam int         c_shw    = $clog2(XLEN);
    localparam logic [5:0] c_nregs  = 6'(NREGS);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_sll  = 4'd2;
    localparam logic [3:0] c_op_slt  = 4'd3;
    localparam logic [3:0] c_op_sltu = 4'd4;
    localparam logic [3:0] c_op_xor  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_or   = 4'd8;
    localparam logic [3:0] c_op_and  = 4'd9;

    // Architectural registers; x0 is not stored and always reads zero.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic            r_de_valid;
    logic [3:0]      r_de_op;
    logic [XLEN-1:0] r_de_a;
    logic [XLEN-1:0] r_de_b;
    logic [4:0]      r_de_rd;
    logic            r_de_illegal;

    logic            r_ew_valid;
    logic [XLEN-1:0] r_ew_result;
    logic [4:0]      r_ew_rd;
    logic            r_ew_illegal;
    logic [31:0]     r_retire_cnt;
    logic [31:0]     r_illegal_cnt;

    logic            w_adv;
    logic            w_accept;
    logic            w_fwd_en;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_shamt_imm;
    logic            w_sh_hi_zero;
    logic            w_sh_hi_sra;
    logic [XLEN-1:0] w_rf_a;
    logic [XLEN-1:0] w_rf_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [3:0]      w_dec_op;
    logic            w_dec_ill;
    logic            w_use_imm;
    logic            w_is_rtype;
    logic [XLEN-1:0] w_alu;
    logic [c_shw-1:0] w_sh;

    assign w_adv    = !r_ew_valid || out_ready;
    assign in_ready = !r_de_valid || w_adv;
    assign w_accept = in_valid && in_ready;

    assign w_rd  = in_instr[11:7];
    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];
    assign w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_shamt_imm = {{(XLEN-c_shw){1'b0}}, in_instr[20 +: c_shw]};
    // Immediate bits above the shift amount: all zero for SLLI/SRLI,
    // only instr[30] set for SRAI (covers both the 32- and 64-bit layouts).
    assign w_sh_hi_zero = (in_instr[31:20+c_shw] == '0);
    assign w_sh_hi_sra  = !in_instr[31] && in_instr[30] && (in_instr[29:20+c_shw] == '0);

    // Decode
    always_comb begin
        w_dec_op   = c_op_add;
        w_dec_ill  = 1'b1;
        w_use_imm  = 1'b0;
        w_is_rtype = 1'b0;
        case (in_instr[6:0])
            7'b0110011: begin
                w_is_rtype = 1'b1;
                w_dec_ill  = 1'b0;
                case ({in_instr[31:25], in_instr[14:12]})
                    {7'b0000000, 3'b000}: w_dec_op = c_op_add;
                    {7'b0100000, 3'b000}: w_dec_op = c_op_sub;
                    {7'b0000000, 3'b001}: w_dec_op = c_op_sll;
                    {7'b0000000, 3'b010}: w_dec_op = c_op_slt;
                    {7'b0000000, 3'b011}: w_dec_op = c_op_sltu;
                    {7'b0000000, 3'b100}: w_dec_op = c_op_xor;
                    {7'b0000000, 3'b101}: w_dec_op = c_op_srl;
                    {7'b0100000, 3'b101}: w_dec_op = c_op_sra;
                    {7'b0000000, 3'b110}: w_dec_op = c_op_or;
                    {7'b0000000, 3'b111}: w_dec_op = c_op_and;
                    default:              w_dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                w_use_imm = 1'b1;
                w_dec_ill = 1'b0;
                case (in_instr[14:12])
                    3'b000: w_dec_op = c_op_add;
                    3'b010: w_dec_op = c_op_slt;
                    3'b011: w_dec_op = c_op_sltu;
                    3'b100: w_dec_op = c_op_xor;
                    3'b110: w_dec_op = c_op_or;
                    3'b111: w_dec_op = c_op_and;
                    3'b001: begin
                        w_dec_op  = c_op_sll;
                        w_dec_ill = !w_sh_hi_zero;
                    end
                    default: begin
                        w_dec_op  = w_sh_hi_sra ? c_op_sra : c_op_srl;
                        w_dec_ill = !(w_sh_hi_zero || w_sh_hi_sra);
                    end
                endcase
            end
            default: w_dec_ill = 1'b1;
        endcase
        // Register indices beyond the implemented file are undecodable.
        if (({1'b0, w_rd} >= c_nregs) || ({1'b0, w_rs1} >= c_nregs) ||
            (w_is_rtype && ({1'b0, w_rs2} >= c_nregs)))
            w_dec_ill = 1'b1;
    end

    // Register file reads (decode operands and debug port)
    always_comb begin
        w_rf_a   = '0;
        w_rf_b   = '0;
        dbg_data = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (w_rs1 == 5'(i))    w_rf_a   = r_regs[i];
            if (w_rs2 == 5'(i))    w_rf_b   = r_regs[i];
            if (dbg_addr == 5'(i)) dbg_data = r_regs[i];
        end
    end

    // The instruction in D/E has not written back yet; bypass its result.
    assign w_fwd_en = r_de_valid && !r_de_illegal && (r_de_rd != 5'd0);
    assign w_op_a   = (w_fwd_en && (r_de_rd == w_rs1)) ? w_alu : w_rf_a;
    always_comb begin
        w_op_b = w_rf_b;
        if (w_use_imm)
            w_op_b = ((w_dec_op == c_op_sll) || (w_dec_op == c_op_srl) ||
                      (w_dec_op == c_op_sra)) ? w_shamt_imm : w_imm;
        else if (w_fwd_en && (r_de_rd == w_rs2))
            w_op_b = w_alu;
    end

    // Execute
    assign w_sh = r_de_b[c_shw-1:0];
    always_comb begin
        w_alu = '0;
        case (r_de_op)
            c_op_add:  w_alu = r_de_a + r_de_b;
            c_op_sub:  w_alu = r_de_a - r_de_b;
            c_op_sll:  w_alu = r_de_a << w_sh;
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_de_a) < $signed(r_de_b))};
            c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, (r_de_a < r_de_b)};
            c_op_xor:  w_alu = r_de_a ^ r_de_b;
            c_op_srl:  w_alu = r_de_a >> w_sh;
            c_op_sra:  w_alu = $signed(r_de_a) >>> w_sh;
            c_op_or:   w_alu = r_de_a | r_de_b;
            c_op_and:  w_alu = r_de_a & r_de_b;
            default:   w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
            r_de_valid    <= 1'b0;
            r_de_op       <= c_op_add;
            r_de_a        <= '0;
            r_de_b        <= '0;
            r_de_rd       <= '0;
            r_de_illegal  <= 1'b0;
            r_ew_valid    <= 1'b0;
            r_ew_result   <= '0;
            r_ew_rd       <= '0;
            r_ew_illegal  <= 1'b0;
            r_retire_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_ew_valid   <= r_de_valid;
                r_ew_result  <= r_de_illegal ? '0 : w_alu;
                r_ew_rd      <= r_de_rd;
                r_ew_illegal <= r_de_illegal;
                if (w_fwd_en) begin
                    for (int i = 1; i < NREGS; i++)
                        if (r_de_rd == 5'(i)) r_regs[i] <= w_alu;
                end
            end
            if (w_accept) begin
                r_de_valid   <= 1'b1;
                r_de_op      <= w_dec_op;
                r_de_a       <= w_op_a;
                r_de_b       <= w_op_b;
                r_de_rd      <= w_rd;
                r_de_illegal <= w_dec_ill;
            end else if (w_adv) begin
                r_de_valid   <= 1'b0;
            end
            if (r_ew_valid && out_ready) begin
                if (r_ew_illegal) r_illegal_cnt <= r_illegal_cnt + 32'd1;
                else              r_retire_cnt  <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign out_valid   = r_ew_valid;
    assign out_result  = r_ew_result;
    assign out_rd      = r_ew_rd;
    assign out_illegal = r_ew_illegal;
    assign retire_cnt  = r_retire_cnt;
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu_pipe
// Description : Directed self-checking bench for riscv_alu_pipe. A second
//               instance with NREGS=16 shares all inputs so out-of-range
//               register indices can be observed side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_alu_pipe;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr  = '0;
    logic [4:0]  dbg_addr  = '0;

    logic        in_ready,  in_ready16;
    logic        out_valid, out_valid16;
    logic [31:0] out_result, out_result16;
    logic [4:0]  out_rd, out_rd16;
    logic        out_illegal, out_illegal16;
    logic [31:0] dbg_data, dbg_data16;
    logic [31:0] retire_cnt, retire_cnt16;
    logic [31:0] illegal_cnt, illegal_cnt16;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_alu_pipe #(.XLEN(32), .NREGS(32)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .retire_cnt(retire_cnt), .illegal_cnt(illegal_cnt)
    );

    riscv_alu_pipe #(.XLEN(32), .NREGS(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready16), .in_instr(in_instr),
        .out_valid(out_valid16), .out_ready(out_ready), .out_result(out_result16),
        .out_rd(out_rd16), .out_illegal(out_illegal16),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data16),
        .retire_cnt(retire_cnt16), .illegal_cnt(illegal_cnt16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction alone and check it one edge after acceptance.
    task automatic run1(input string tag, input logic [31:0] ins,
                        input logic [31:0] er, input logic [4:0] erd, input logic eill);
        in_valid = 1'b1;
        in_instr = ins;
        tick;
        in_valid = 1'b0;
        in_instr = '0;
        tick;
        chk({tag, ".valid"},   {31'd0, out_valid},   32'd1);
        chk({tag, ".result"},  out_result,           er);
        chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, eill});
        if (!eill) chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, erd});
    endtask

    task automatic chkreg(input string tag, input logic [4:0] a, input logic [31:0] e);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, e);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid",   {31'd0, out_valid},   32'd0);
        chk("rst.out_result",  out_result,           32'd0);
        chk("rst.out_rd",      {27'd0, out_rd},      32'd0);
        chk("rst.out_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst.retire_cnt",  retire_cnt,           32'd0);
        chk("rst.illegal_cnt", illegal_cnt,          32'd0);
        reset = 1'b1;
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chkreg("rst.x1", 5'd1, 32'd0);

        // Back-to-back with forwarding: ADDI x1,x0,5 ; ADD x2,x1,x1
        in_valid = 1'b1;
        in_instr = it(12'd5, 5'd0, 3'b000, 5'd1);
        tick;
        in_instr = rt(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        tick;
        chk("b2b.valid0",  {31'd0, out_valid}, 32'd1);
        chk("b2b.result0", out_result, 32'd5);
        chk("b2b.rd0",     {27'd0, out_rd}, 32'd1);
        in_valid = 1'b0;
        tick;
        chk("b2b.valid1",  {31'd0, out_valid}, 32'd1);
        chk("b2b.result1", out_result, 32'd10);
        chk("b2b.rd1",     {27'd0, out_rd}, 32'd2);
        chkreg("b2b.x2", 5'd2, 32'd10);
        chkreg("b2b.x1", 5'd1, 32'd5);
        tick;
        chk("b2b.retire",  retire_cnt, 32'd2);
        chk("b2b.drained", {31'd0, out_valid}, 32'd0);

        // Shifts, compares, arithmetic
        run1("addi_m1", it(12'hFFF, 5'd0, 3'b000, 5'd3), 32'hFFFF_FFFF, 5'd3, 1'b0);
        run1("srai",    it(12'h404, 5'd3, 3'b101, 5'd4), 32'hFFFF_FFFF, 5'd4, 1'b0);
        run1("srli",    it(12'h01C, 5'd3, 3'b101, 5'd5), 32'h0000_000F, 5'd5, 1'b0);
        run1("sltu",    rt(7'h00, 5'd3, 5'd0, 3'b011, 5'd6), 32'd1, 5'd6, 1'b0);
        run1("slt",     rt(7'h00, 5'd0, 5'd3, 3'b010, 5'd7), 32'd1, 5'd7, 1'b0);
        run1("sub",     rt(7'h20, 5'd2, 5'd1, 3'b000, 5'd8), 32'hFFFF_FFFB, 5'd8, 1'b0);
        run1("sll",     rt(7'h00, 5'd1, 5'd1, 3'b001, 5'd9), 32'h0000_00A0, 5'd9, 1'b0);
        run1("xori",    it(12'h0F0, 5'd8, 3'b100, 5'd14), 32'hFFFF_FF0B, 5'd14, 1'b0);
        run1("sltiu",   it(12'hFFF, 5'd0, 3'b011, 5'd15), 32'd1, 5'd15, 1'b0);
        tick;
        chk("alu.retire", retire_cnt, 32'd11);
        chkreg("alu.x4", 5'd4, 32'hFFFF_FFFF);
        chkreg("alu.x5", 5'd5, 32'h0000_000F);

        // Back-pressure with two instructions in flight
        out_ready = 1'b0;
        dbg_addr  = 5'd11;
        in_valid  = 1'b1;
        in_instr  = it(12'd11, 5'd0, 3'b000, 5'd10);
        tick;
        in_instr  = it(12'd1, 5'd10, 3'b000, 5'd11);
        tick;
        in_instr  = it(12'd99, 5'd0, 3'b000, 5'd12);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall.valid",    {31'd0, out_valid}, 32'd1);
            chk("stall.result",   out_result, 32'd11);
            chk("stall.rd",       {27'd0, out_rd}, 32'd10);
            chk("stall.retire",   retire_cnt, 32'd11);
            chk("stall.x11",      dbg_data, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("rel.result", out_result, 32'd12);
        chk("rel.rd",     {27'd0, out_rd}, 32'd11);
        chk("rel.retire", retire_cnt, 32'd12);
        tick;
        chk("rel.retire2", retire_cnt, 32'd13);
        chk("rel.valid",   {31'd0, out_valid}, 32'd0);
        chk("rel.x11",     dbg_data, 32'd12);
        chkreg("rel.x12", 5'd12, 32'd0);

        // Illegal encodings
        run1("ill_ones", 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1);
        run1("ill_sub",  rt(7'h20, 5'd1, 5'd1, 3'b001, 5'd12), 32'd0, 5'd0, 1'b1);
        tick;
        chk("ill.cnt",    illegal_cnt, 32'd2);
        chk("ill.retire", retire_cnt, 32'd13);
        chkreg("ill.x12", 5'd12, 32'd0);
        chkreg("ill.x31", 5'd31, 32'd0);

        // x0 destination and out-of-range index on the 16-register instance
        run1("addi_x0", it(12'd7, 5'd0, 3'b000, 5'd0), 32'd7, 5'd0, 1'b0);
        run1("addi_x20", it(12'd3, 5'd0, 3'b000, 5'd20), 32'd3, 5'd20, 1'b0);
        chk("n16.valid",   {31'd0, out_valid16},   32'd1);
        chk("n16.illegal", {31'd0, out_illegal16}, 32'd1);
        chk("n16.result",  out_result16,           32'd0);
        tick;
        chkreg("x0.read", 5'd0, 32'd0);
        dbg_addr = 5'd20;
        #1;
        chk("x20.n32", dbg_data,   32'd3);
        chk("x20.n16", dbg_data16, 32'd0);
        chk("n16.illcnt", illegal_cnt16, 32'd3);

        // Asynchronous reset with instructions in flight
        dbg_addr = 5'd17;
        in_valid = 1'b1;
        in_instr = it(12'd9, 5'd0, 3'b000, 5'd13);
        tick;
        in_instr = it(12'd6, 5'd0, 3'b000, 5'd17);
        tick;
        in_valid = 1'b0;
        chk("arst.pre_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst.valid",   {31'd0, out_valid}, 32'd0);
        chk("arst.result",  out_result, 32'd0);
        chk("arst.retire",  retire_cnt, 32'd0);
        chk("arst.illcnt",  illegal_cnt, 32'd0);
        chk("arst.x17",     dbg_data, 32'd0);
        reset = 1'b1;
        tick;
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst.valid2",   {31'd0, out_valid}, 32'd0);
        chk("arst.x17b",     dbg_data, 32'd0);
        chkreg("arst.x13", 5'd13, 32'd0);
        run1("post_rst", it(12'd1, 5'd0, 3'b000, 5'd1), 32'd1, 5'd1, 1'b0);
        tick;
        chk("post_rst.retire", retire_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
